ram_arbiter: RTL and testbench

Round-robin arbiter that shares one single-port RAM between `numPorts` requesters, such as processor cores and the channel controller. Each access runs as a fixed two-cycle RAM transaction: an issue cycle, then a completion cycle. This is the same access shape the memory test exercises. The block sits between the requesters and the RAM: it latches one request at a time, drives the RAM, and returns read data with a per-port completion pulse.

---
 rtl/ram_arbiter_if.sv | 30 +++
 rtl/ram_arbiter.sv | 128 ++++++++++++
 tb/tb_ram_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Requester-side and RAM-side signal bundle for ram_arbiter.
// The arbiter takes the slave modport; requesters and the RAM sit on the master side.
interface ram_arbiter_if #(
   parameter int unsigned addrBits = 16,
   parameter int unsigned dataBits = 16,
   parameter int unsigned numPorts = 4
);
   logic [numPorts-1:0]          reqValid;
   logic [numPorts-1:0]          reqWrite;
   logic [numPorts*addrBits-1:0] reqAddress;
   logic [numPorts*dataBits-1:0] reqData;
   logic [numPorts-1:0]          reqAccept;
   logic [numPorts-1:0]          respValid;
   logic [dataBits-1:0]          respData;
   logic                         busy;
   logic [dataBits-1:0]          ramDataOut;
   logic                         ramReadWriteMode;
   logic [dataBits-1:0]          ramDataIn;
   logic [addrBits-1:0]          ramAddress;

   modport slave (
      input  reqValid, reqWrite, reqAddress, reqData, ramDataOut,
      output reqAccept, respValid, respData, busy, ramReadWriteMode, ramDataIn, ramAddress
   );

   modport master (
      output reqValid, reqWrite, reqAddress, reqData, ramDataOut,
      input  reqAccept, respValid, respData, busy, ramReadWriteMode, ramDataIn, ramAddress
   );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM; each access is a fixed
// issue + completion cycle pair, followed by a registered per-port response pulse.
module ram_arbiter #(
   parameter int unsigned addrBits = 16,
   parameter int unsigned dataBits = 16,
   parameter int unsigned numPorts = 4
) (
   input logic          clk,
   input logic          reset,
   ram_arbiter_if.slave bus
);
   localparam int unsigned PtrW = $clog2(numPorts);
   localparam logic RAM_READ  = 1'b0;
   localparam logic RAM_WRITE = 1'b1;
   localparam logic [numPorts-1:0] PortOne = {{(numPorts-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

   state_e              state_q, state_d;
   logic [PtrW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [PtrW-1:0]     win_q, win_d;
   logic                write_q, write_d;
   logic [addrBits-1:0] addr_q, addr_d;
   logic [dataBits-1:0] data_q, data_d;
   logic [numPorts-1:0] resp_valid_q, resp_valid_d;
   logic [dataBits-1:0] resp_data_q, resp_data_d;
   logic [numPorts-1:0] accept;

   logic                any_req;
   logic [PtrW-1:0]     pick;
   int unsigned         cand;
   logic                pick_write;
   logic [addrBits-1:0] pick_addr;
   logic [dataBits-1:0] pick_data;
   logic                driving;

   // First pending port at or above rr_ptr_q, wrapping modulo numPorts.
   always_comb begin
      any_req = 1'b0;
      pick    = '0;
      cand    = 0;
      for (int unsigned k = 0; k < numPorts; k++) begin
         cand = 32'(rr_ptr_q) + k;
         if (cand >= numPorts) cand = cand - numPorts;
         if (!any_req && bus.reqValid[PtrW'(cand)]) begin
            any_req = 1'b1;
            pick    = PtrW'(cand);
         end
      end
   end

   always_comb begin
      pick_write = 1'b0;
      pick_addr  = '0;
      pick_data  = '0;
      for (int unsigned i = 0; i < numPorts; i++) begin
         if (pick == PtrW'(i)) begin
            pick_write = bus.reqWrite[i];
            pick_addr  = bus.reqAddress[i*addrBits +: addrBits];
            pick_data  = bus.reqData[i*dataBits +: dataBits];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      win_d        = win_q;
      write_d      = write_q;
      addr_d       = addr_q;
      data_d       = data_q;
      resp_valid_d = '0;
      resp_data_d  = resp_data_q;
      accept       = '0;
      unique case (state_q)
         StIdle: begin
            if (any_req) begin
               accept   = PortOne << pick;
               win_d    = pick;
               write_d  = pick_write;
               addr_d   = pick_addr;
               data_d   = pick_data;
               rr_ptr_d = (pick == PtrW'(numPorts - 1)) ? '0 : pick + 1'b1;
               state_d  = StIssue;
            end
         end
         StIssue: state_d = StWait;
         StWait: begin
            resp_valid_d = PortOne << win_q;
            if (!write_q) resp_data_d = bus.ramDataOut;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= StIdle;
         rr_ptr_q     <= '0;
         win_q        <= '0;
         write_q      <= 1'b0;
         addr_q       <= '0;
         data_q       <= '0;
         resp_valid_q <= '0;
         resp_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         win_q        <= win_d;
         write_q      <= write_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
      end
   end

   // RAM is only driven from the latch in ISSUE/WAIT, so idle cycles can never write.
   assign driving              = (state_q != StIdle);
   assign bus.busy             = driving;
   assign bus.ramReadWriteMode = (driving && write_q) ? RAM_WRITE : RAM_READ;
   assign bus.ramAddress       = driving ? addr_q : '0;
   assign bus.ramDataIn        = driving ? data_q : '0;
   assign bus.reqAccept        = reset ? accept : '0;
   assign bus.respValid        = resp_valid_q;
   assign bus.respData         = resp_data_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ram_arbiter;
   localparam int NP = 4;
   localparam logic RAM_READ  = 1'b0;
   localparam logic RAM_WRITE = 1'b1;

   typedef struct {
      logic        wr;
      logic [15:0] addr;
      logic [15:0] data;
   } req_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   ram_arbiter_if #(.addrBits(16), .dataBits(16), .numPorts(NP)) bus ();
   ram_arbiter #(.addrBits(16), .dataBits(16), .numPorts(NP)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] preload(input logic [15:0] a);
      if (a == 16'h1234) return 16'hBEEF;
      return {a[7:0], a[15:8]} ^ 16'h5A5A;
   endfunction

   // RAM under the arbiter: sparse contents over the preload pattern.
   logic [15:0] ram [int unsigned];
   logic [15:0] ram_dout = 16'h0;
   assign bus.ramDataOut = ram_dout;

   function automatic logic [15:0] ram_rd(input logic [15:0] a);
      return ram.exists(32'(a)) ? ram[32'(a)] : preload(a);
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         if (bus.ramReadWriteMode == RAM_WRITE) ram[32'(bus.ramAddress)] = bus.ramDataIn;
         ram_dout = ram_rd(bus.ramAddress);
      end
   end

   // Requesters: one queue per port, front entry is presented until accepted.
   req_t rq [NP][$];
   logic [NP-1:0] acc_seen = '0;
   logic [NP-1:0] mask = '0;

   task automatic drive();
      logic [NP-1:0]    v, w;
      logic [NP*16-1:0] a, d;
      v = '0; w = '0; a = '0; d = '0;
      for (int p = 0; p < NP; p++) begin
         if (acc_seen[p] && rq[p].size() > 0) rq[p].delete(0);
         if (rq[p].size() > 0) begin
            v[p] = !mask[p];
            w[p] = rq[p][0].wr;
            a[p*16 +: 16] = rq[p][0].addr;
            d[p*16 +: 16] = rq[p][0].data;
         end
      end
      bus.reqValid = v;
      bus.reqWrite = w;
      bus.reqAddress = a;
      bus.reqData = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic push(input int p, input logic wr, input logic [15:0] a, input logic [15:0] d);
      req_t r;
      r.wr = wr; r.addr = a; r.data = d;
      rq[p].push_back(r);
   endtask

   task automatic do_reset();
      tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   // Reference model: at most one transaction in flight, timed from its accept cycle.
   bit check_en = 1'b0;
   logic [15:0] ref_mem [int unsigned];

   function automatic logic [15:0] ref_rd(input logic [15:0] a);
      return ref_mem.exists(32'(a)) ? ref_mem[32'(a)] : preload(a);
   endfunction

   initial begin
      int cyc, m_t0, m_port, m_rr, w;
      bit m_have, m_wr, exp_drv;
      logic [15:0] m_addr, m_data, m_rdata, m_resp;
      logic [NP-1:0] exp_acc, exp_rv;
      cyc = 0; m_t0 = 0; m_port = 0; m_rr = 0; m_have = 0; m_wr = 0;
      m_addr = 0; m_data = 0; m_rdata = 0; m_resp = 0;
      forever begin
         @(negedge clk);
         acc_seen = bus.reqAccept;
         if (check_en) begin
            exp_drv = m_have && (cyc == m_t0 + 1 || cyc == m_t0 + 2);
            chk("busy", bus.busy, exp_drv);
            chk("ram_mode", bus.ramReadWriteMode, (exp_drv && m_wr) ? RAM_WRITE : RAM_READ);
            chk("ram_addr", bus.ramAddress, exp_drv ? m_addr : 16'h0);
            if (!exp_drv) chk("ram_din_idle", bus.ramDataIn, 0);
            else if (m_wr) chk("ram_din_write", bus.ramDataIn, m_data);
            exp_rv = '0;
            if (m_have && cyc == m_t0 + 3) begin
               exp_rv[m_port] = 1'b1;
               if (!m_wr) m_resp = m_rdata;
               m_have = 0;
            end
            chk("resp_valid", bus.respValid, exp_rv);
            chk("resp_data", bus.respData, m_resp);
            exp_acc = '0;
            if (reset && !m_have) begin
               w = -1;
               for (int k = 0; k < NP; k++) begin
                  int idx;
                  idx = (m_rr + k) % NP;
                  if (w < 0 && bus.reqValid[idx]) w = idx;
               end
               if (w >= 0) begin
                  exp_acc[w] = 1'b1;
                  m_have = 1; m_t0 = cyc; m_port = w;
                  m_wr = bus.reqWrite[w];
                  m_addr = bus.reqAddress[w*16 +: 16];
                  m_data = bus.reqData[w*16 +: 16];
                  if (m_wr) ref_mem[32'(m_addr)] = m_data;
                  else m_rdata = ref_rd(m_addr);
                  m_rr = (w + 1) % NP;
               end
            end
            chk("req_accept", bus.reqAccept, exp_acc);
            if (!reset) begin
               m_have = 0; m_rr = 0; m_resp = 0;
            end
         end
         cyc++;
      end
   end

   initial begin
      int nacc, wr_cycles, n;
      int acc_q[$];
      drive();
      @(posedge clk);
      #1;
      check_en = 1'b1;

      // Reset state, with a request pending that must not be accepted.
      push(3, 1'b0, 16'h0010, 16'h0);
      tick();
      @(negedge clk);
      chk("rst_accept", bus.reqAccept, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_resp_valid", bus.respValid, 0);
      chk("rst_resp_data", bus.respData, 0);
      chk("rst_mode", bus.ramReadWriteMode, RAM_READ);
      chk("rst_addr", bus.ramAddress, 0);
      rq[3].delete();
      tick();
      reset = 1'b1;

      // Single read
      push(2, 1'b0, 16'h1234, 16'h0);
      tick(); @(negedge clk);
      chk("single_accept", bus.reqAccept, 4'b0100);
      for (int c = 1; c <= 2; c++) begin
         tick(); @(negedge clk);
         chk("single_addr", bus.ramAddress, 16'h1234);
         chk("single_mode", bus.ramReadWriteMode, RAM_READ);
      end
      tick(); @(negedge clk);
      chk("single_resp_valid", bus.respValid, 4'b0100);
      chk("single_resp_data", bus.respData, 16'hBEEF);

      // Write then read on port 1
      push(1, 1'b1, 16'hFFFF, 16'hA5A5);
      push(1, 1'b0, 16'hFFFF, 16'h0);
      wr_cycles = 0;
      for (int c = 0; c < 8; c++) begin
         tick(); @(negedge clk);
         if (bus.ramReadWriteMode == RAM_WRITE) begin
            wr_cycles++;
            chk("wr_din", bus.ramDataIn, 16'hA5A5);
            chk("wr_addr", bus.ramAddress, 16'hFFFF);
         end
         if (c == 3) chk("wr_second_accept", bus.reqAccept, 4'b0010);
         if (c == 6) begin
            chk("wr_read_valid", bus.respValid, 4'b0010);
            chk("wr_read_data", bus.respData, 16'hA5A5);
         end
      end
      chk("wr_cycle_count", wr_cycles, 2);
      chk("wr_neighbour", ram_rd(16'hFFFE), 16'hA4A5);

      // Contention from a fresh pointer
      do_reset();
      for (int p = 0; p < NP; p++) push(p, 1'b0, 16'(16'h0200 + p), 16'h0);
      nacc = 0;
      for (int c = 0; c < 14; c++) begin
         tick(); @(negedge clk);
         if (bus.reqAccept != 0) begin
            chk("cont_port", bus.reqAccept, 4'(4'b0001 << nacc));
            chk("cont_cycle", c, 3 * nacc);
            nacc++;
         end
      end
      chk("cont_count", nacc, 4);

      // Fairness between ports 0 and 3
      for (int i = 0; i < 4; i++) begin
         push(0, 1'b0, 16'(16'h0400 + i), 16'h0);
         push(3, 1'b0, 16'(16'h0480 + i), 16'h0);
      end
      nacc = 0;
      for (int c = 0; c < 26; c++) begin
         tick(); @(negedge clk);
         if (bus.reqAccept != 0) begin
            chk("fair_port", bus.reqAccept, (nacc % 2 == 0) ? 4'b0001 : 4'b1000);
            chk("fair_cycle", c, 3 * nacc);
            nacc++;
         end
      end
      chk("fair_count", nacc, 8);

      // Reset during WAIT of a read
      push(1, 1'b0, 16'h0300, 16'h0);
      tick(); @(negedge clk);
      chk("rmid_accept", bus.reqAccept, 4'b0010);
      tick();
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("rmid_wait_busy", bus.busy, 1);
      tick();
      reset = 1'b1;
      @(negedge clk);
      chk("rmid_no_resp", bus.respValid, 0);
      chk("rmid_busy", bus.busy, 0);
      chk("rmid_mode", bus.ramReadWriteMode, RAM_READ);
      push(0, 1'b0, 16'h0310, 16'h0);
      push(2, 1'b0, 16'h0320, 16'h0);
      tick(); @(negedge clk);
      chk("rmid_ptr_zero", bus.reqAccept, 4'b0001);
      for (int c = 0; c < 8; c++) tick();

      // Back-to-back sweep on port 0
      for (int i = 0; i < 64; i++) push(0, 1'b0, 16'(16'h0100 + i), 16'h0);
      n = 0;
      for (int c = 0; c < 64 * 3 + 4; c++) begin
         tick(); @(negedge clk);
         if (bus.reqAccept[0]) acc_q.push_back(c);
         if (bus.respValid[0]) begin
            if (acc_q.size() > 0) chk("sweep_latency", c - acc_q.pop_front(), 3);
            else chk("sweep_orphan_resp", 1, 0);
            chk("sweep_data", bus.respData, {8'(n) ^ 8'h5A, 8'h5B});
            n++;
         end
      end
      chk("sweep_count", n, 64);

      // Randomized traffic with occasional resets and withdrawn requests
      for (int c = 0; c < 2000; c++) begin
         tick();
         reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
         for (int p = 0; p < NP; p++) begin
            if (rq[p].size() < 2 && $urandom_range(0, 3) == 0)
               push(p, 1'($urandom_range(0, 1)), 16'(16'hA000 + $urandom_range(0, 15)),
                    16'($urandom));
            mask[p] = ($urandom_range(0, 7) == 0);
         end
      end
      tick();
      reset = 1'b1;
      mask = '0;
      for (int c = 0; c < 100; c++) begin
         tick();
         if (rq[0].size() + rq[1].size() + rq[2].size() + rq[3].size() == 0) break;
      end
      chk("drain_empty", rq[0].size() + rq[1].size() + rq[2].size() + rq[3].size(), 0);
      for (int c = 0; c < 5; c++) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
